jtopl_pg: RTL and testbench

Phase generator for the OPL operator pipeline. It consumes the 3-bit vibrato phase `vib_cnt` produced by the LFO counter and applies the vibrato offset to each slot's F-number. It converts the F-number, block and multiplier into a phase increment and accumulates one 20-bit phase per slot. The 10-bit operator phase is delivered to the waveform/operator stage. It runs on the shared `cenop` slot enable, one slot per tick, 18 slots per sample.

---
 rtl/jtopl_pg.sv | 109 ++++++++++
 tb/tb_jtopl_pg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_pg.sv
// jtopl_pg: OPL phase generator.
// Applies vibrato to the F-number, turns F-number/block/multiplier into a
// phase increment, and keeps one 20-bit phase accumulator per slot in a
// SLOTS-deep shift ring. One slot advances per cenop tick.
module jtopl_pg #(
  parameter int SLOTS = 18
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cenop,
  input  logic [2:0] vib_cnt,
  input  logic [9:0] fnum_I,
  input  logic [2:0] block_I,
  input  logic       viben_I,
  input  logic       vib_dep,
  input  logic [3:0] mul_II,
  input  logic       pg_rst_III,
  output logic [9:0] phase_IV
);

  // Stage I -> II signals
  logic [2:0]  vib_d;
  logic [2:0]  vib_mag;
  logic        vib_neg;
  logic [10:0] fmod_d, fmod_II_q;
  logic [2:0]  block_II_q;

  // Stage II -> III signals
  logic [17:0] pre;
  logic [4:0]  mt;
  logic [22:0] prod;
  logic [19:0] inc_d, inc_III_q;

  // Stage III -> IV signals
  logic [19:0] acc_old;
  logic [19:0] acc_d;
  logic [19:0] ring_q [SLOTS];
  logic [9:0]  phase_q;

  // Vibrato offset: magnitude and sign chosen by the LFO phase
  always_comb begin
    vib_d   = fnum_I[9:7];
    if (!vib_dep) vib_d = vib_d >> 1;
    vib_mag = '0;
    vib_neg = 1'b0;
    case (vib_cnt)
      3'd1, 3'd3: vib_mag = vib_d >> 1;
      3'd2:       vib_mag = vib_d;
      3'd5, 3'd7: begin vib_mag = vib_d >> 1; vib_neg = 1'b1; end
      3'd6:       begin vib_mag = vib_d;      vib_neg = 1'b1; end
      default:    vib_mag = '0;
    endcase
    if (!viben_I) vib_mag = '0;
    // offset never exceeds fnum_I[9:7], so subtraction cannot underflow
    if (vib_neg) fmod_d = {1'b0, fnum_I} - {8'd0, vib_mag};
    else         fmod_d = {1'b0, fnum_I} + {8'd0, vib_mag};
  end

  // Multiplier table and phase increment
  always_comb begin
    pre = {7'd0, fmod_II_q} << block_II_q;
    case (mul_II)
      4'd0:  mt = 5'd1;
      4'd1:  mt = 5'd2;
      4'd2:  mt = 5'd4;
      4'd3:  mt = 5'd6;
      4'd4:  mt = 5'd8;
      4'd5:  mt = 5'd10;
      4'd6:  mt = 5'd12;
      4'd7:  mt = 5'd14;
      4'd8:  mt = 5'd16;
      4'd9:  mt = 5'd18;
      4'd10: mt = 5'd20;
      4'd11: mt = 5'd20;
      4'd12: mt = 5'd24;
      4'd13: mt = 5'd24;
      default: mt = 5'd30;
    endcase
    prod  = {5'd0, pre} * {18'd0, mt};
    inc_d = prod[21:2];
  end

  // Accumulate onto the ring tail; restart wins over accumulation
  always_comb begin
    acc_old = ring_q[SLOTS-1];
    acc_d   = pg_rst_III ? '0 : acc_old + inc_III_q;
  end

  // Pipeline registers, accumulator ring and output phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmod_II_q  <= '0;
      block_II_q <= '0;
      inc_III_q  <= '0;
      phase_q    <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) ring_q[i] <= '0;
    end else if (cenop) begin
      fmod_II_q  <= fmod_d;
      block_II_q <= block_I;
      inc_III_q  <= inc_d;
      phase_q    <= acc_d[19:10];
      ring_q[0]  <= acc_d;
      for (int unsigned i = 1; i < SLOTS; i++) ring_q[i] <= ring_q[i-1];
    end
  end

  assign phase_IV = phase_q;

endmodule

// File: tb/tb_jtopl_pg.sv
// Scoreboard bench for jtopl_pg: stimulus pushes the expected phase of each
// issued slot, a monitor pops and compares after each cenop edge.
module tb_jtopl_pg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cenop = 1'b0;
  logic [2:0] vib_cnt = '0;
  logic [9:0] fnum_I = '0;
  logic [2:0] block_I = '0;
  logic       viben_I = 1'b0;
  logic       vib_dep = 1'b0;
  logic [3:0] mul_II = '0;
  logic       pg_rst_III = 1'b0;
  logic [9:0] phase_IV;

  always #5 clk = ~clk;

  jtopl_pg #(.SLOTS(18)) dut (
    .rst(rst), .clk(clk), .cenop(cenop), .vib_cnt(vib_cnt),
    .fnum_I(fnum_I), .block_I(block_I), .viben_I(viben_I),
    .vib_dep(vib_dep), .mul_II(mul_II), .pg_rst_III(pg_rst_III),
    .phase_IV(phase_IV)
  );

  typedef struct {
    logic [9:0]  fnum;
    logic [2:0]  blk;
    logic        viben;
    logic        vdep;
    logic [2:0]  vcnt;
    logic [3:0]  mul;
    logic [19:0] inc;   // hand-computed phase increment
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [9:0]  exp;
    int unsigned slot;
  } exp_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned ecount = 0;
  int unsigned idx = 0;
  exp_t        sbq[$];
  logic [9:0]  last_exp = '0;
  logic [19:0] acc [18];
  logic [3:0]  mul_d1 = '0;
  logic        rst_d1 = 1'b0;
  logic        rst_d2 = 1'b0;
  vec_t        tbl [18];
  vec_t        basic;

  function automatic vec_t mk(input logic [9:0] f, input logic [2:0] b,
                              input logic ve, input logic vd,
                              input logic [2:0] vc, input logic [3:0] m,
                              input logic [19:0] inc);
    vec_t v;
    v.fnum = f; v.blk = b; v.viben = ve; v.vdep = vd;
    v.vcnt = vc; v.mul = m; v.inc = inc;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] got,
                       input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: phase_IV=%0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: after every cenop edge, compare the output due at that edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (cenop && !rst) begin
        ecount++;
        #1;
        while (sbq.size() > 0 && sbq[0].due < ecount) begin
          e = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missed slot%0d: due edge %0d, now %0d", e.slot, e.due, ecount);
        end
        if (sbq.size() > 0 && sbq[0].due == ecount) begin
          e = sbq.pop_front();
          check($sformatf("slot%0d", e.slot), phase_IV, e.exp);
          last_exp = e.exp;
        end
      end
    end
  end

  // Issue one slot at stage I; later-stage inputs come from bench shadows
  task automatic issue(input vec_t v, input logic prst);
    exp_t        e;
    int unsigned s;
    @(negedge clk);
    fnum_I     = v.fnum;
    block_I    = v.blk;
    viben_I    = v.viben;
    vib_dep    = v.vdep;
    vib_cnt    = v.vcnt;
    mul_II     = mul_d1;
    pg_rst_III = rst_d2;
    rst_d2     = rst_d1;
    rst_d1     = prst;
    mul_d1     = v.mul;
    cenop      = 1'b1;
    s      = idx % 18;
    acc[s] = prst ? 20'd0 : acc[s] + v.inc;
    e.due  = ecount + 3;
    e.exp  = acc[s][19:10];
    e.slot = s;
    sbq.push_back(e);
    idx++;
  endtask

  // Hold cenop low; output must stay at the last delivered phase
  task automatic gap();
    @(negedge clk);
    cenop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0 || i == 50 || i == 99) check("gate_hold", phase_IV, last_exp);
    end
  endtask

  // Asynchronous reset between edges, then restart bench state
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", phase_IV, 10'd0);
    cenop      = 1'b0;
    sbq.delete();
    for (int i = 0; i < 18; i++) acc[i] = '0;
    idx        = 0;
    mul_d1     = '0;
    rst_d1     = 1'b0;
    rst_d2     = 1'b0;
    mul_II     = '0;
    pg_rst_III = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push the last in-flight slots through stages II and III
  task automatic drain();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mul_II     = mul_d1;
      pg_rst_III = rst_d2;
      rst_d2     = rst_d1;
      rst_d1     = 1'b0;
      mul_d1     = '0;
      cenop      = 1'b1;
    end
    @(negedge clk);
    cenop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 18; i++) acc[i] = '0;
    basic   = mk(10'h200, 3'd4, 1'b0, 1'b0, 3'd0, 4'd1, 20'd4096);
    tbl[0]  = mk(10'h380, 3'd0, 1'b1, 1'b1, 3'd6, 4'd1, 20'd444);
    tbl[1]  = mk(10'h380, 3'd0, 1'b1, 1'b1, 3'd2, 4'd1, 20'd451);
    tbl[2]  = mk(10'h380, 3'd0, 1'b1, 1'b0, 3'd2, 4'd1, 20'd449);
    tbl[3]  = mk(10'h380, 3'd0, 1'b1, 1'b1, 3'd0, 4'd1, 20'd448);
    tbl[4]  = mk(10'h380, 3'd0, 1'b1, 1'b1, 3'd4, 4'd1, 20'd448);
    tbl[5]  = mk(10'h380, 3'd7, 1'b1, 1'b1, 3'd6, 4'd1, 20'd56896);
    tbl[6]  = mk(10'h380, 3'd7, 1'b1, 1'b1, 3'd2, 4'd1, 20'd57792);
    tbl[7]  = mk(10'h380, 3'd7, 1'b1, 1'b0, 3'd2, 4'd1, 20'd57536);
    tbl[8]  = mk(10'h380, 3'd7, 1'b0, 1'b1, 3'd6, 4'd1, 20'd57344);
    tbl[9]  = mk(10'h100, 3'd2, 1'b0, 1'b1, 3'd0, 4'd0, 20'd256);
    tbl[10] = mk(10'h100, 3'd2, 1'b0, 1'b1, 3'd0, 4'd10, 20'd5120);
    tbl[11] = mk(10'h100, 3'd2, 1'b0, 1'b1, 3'd0, 4'd11, 20'd5120);
    tbl[12] = mk(10'h100, 3'd2, 1'b0, 1'b1, 3'd0, 4'd15, 20'd7680);
    tbl[13] = mk(10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd15, 20'd988800);
    tbl[14] = mk(10'h3FF, 3'd7, 1'b1, 1'b1, 3'd1, 4'd12, 20'd787968);
    tbl[15] = mk(10'h0FF, 3'd3, 1'b1, 1'b1, 3'd5, 4'd2, 20'd2040);
    tbl[16] = mk(10'h2AB, 3'd5, 1'b1, 1'b1, 3'd7, 4'd3, 20'd32688);
    tbl[17] = mk(10'h155, 3'd1, 1'b1, 1'b0, 3'd3, 4'd5, 20'd1705);

    #1 check("reset_state", phase_IV, 10'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic increment: 257 samples so every slot wraps at update 256
    for (int n = 0; n < 257 * 18; n++) issue(basic, 1'b0);

    do_reset();

    // Vibrato / multiplier vectors, with a restart and a cenop gap
    for (int samp = 0; samp < 30; samp++) begin
      for (int s = 0; s < 18; s++) begin
        issue(tbl[s], (samp == 20 && s == 10) ? 1'b1 : 1'b0);
        if (samp == 12 && s == 7) gap();
      end
    end

    // Reset mid-sample, then confirm every slot starts again from zero
    for (int s = 0; s < 9; s++) issue(tbl[s], 1'b0);
    do_reset();
    for (int samp = 0; samp < 3; samp++)
      for (int s = 0; s < 18; s++) issue(tbl[s], 1'b0);

    drain();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs left unchecked, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
